// File: rtl/ma216_audio_pkg.sv
// Shared constants and helpers for the sound-board audio output path.
package ma216_audio_pkg;

   localparam logic [7:0]         DAC_MIDPOINT = 8'h80;
   localparam logic signed [15:0] SAMPLE_MAX   = 16'sh7FFF;
   localparam logic signed [15:0] SAMPLE_MIN   = 16'sh8000;

   function automatic logic [15:0] sat16(input logic signed [17:0] v);
      if (v > 18'(SAMPLE_MAX)) begin
         return SAMPLE_MAX;
      end else if (v < 18'(SAMPLE_MIN)) begin
         return SAMPLE_MIN;
      end else begin
         return v[15:0];
      end
   endfunction

endpackage

// File: rtl/ma216_dc_block.sv
// One-pole DC blocker: y = x - x_prev + y_prev - y_prev * 2^-HP_SHIFT, saturated to 16 bits.
module ma216_dc_block
   import ma216_audio_pkg::*;
#(
   parameter int HP_SHIFT = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [15:0] x,
   output logic [15:0] y
);

   logic [15:0]        x_prev;
   logic signed [17:0] x_ext;
   logic signed [17:0] xp_ext;
   logic signed [17:0] y_ext;
   logic signed [17:0] y_next;

   // y itself is the y_prev state; 18 bits holds the worst-case sum before saturation
   always_comb begin
      x_ext  = $signed({{2{x[15]}}, x});
      xp_ext = $signed({{2{x_prev[15]}}, x_prev});
      y_ext  = $signed({{2{y[15]}}, y});
      y_next = x_ext - xp_ext + y_ext - (y_ext >>> HP_SHIFT);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         x_prev <= '0;
         y      <= '0;
      end else if (enable) begin
         x_prev <= x;
         y      <= sat16(y_next);
      end
   end

endmodule

// File: rtl/ma216_audio_out.sv
// Decimates the 8-bit DAC latch to one sample per window, then DC-blocks, low-passes and scales it.
module ma216_audio_out
   import ma216_audio_pkg::*;
#(
   parameter int DIV_LOG2 = 5,
   parameter int HP_SHIFT = 8,
   parameter int LP_SHIFT = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  dac_in,
   input  logic [1:0]  volume,
   input  logic        mute,
   output logic [15:0] sample_out,
   output logic        sample_valid
);

   localparam int ACC_W = 8 + DIV_LOG2;

   logic [DIV_LOG2-1:0] cnt;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_total;
   logic                wrap;
   logic [7:0]          avg;
   logic [15:0]         x_q;
   logic [15:0]         y;
   logic [15:0]         z_prev;
   logic                v0;
   logic                v1;
   logic                v2;
   logic signed [16:0]  z_diff;
   logic signed [15:0]  z_cur;

   always_comb begin
      wrap      = &cnt;
      acc_total = acc + ACC_W'(dac_in);
      z_diff    = $signed({y[15], y}) - $signed({z_prev[15], z_prev});
      // Result always lies between y and z_prev, so 16-bit wraparound arithmetic is exact
      z_cur     = $signed(z_prev) + $signed(16'(z_diff >>> LP_SHIFT));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt          <= '0;
         acc          <= '0;
         avg          <= '0;
         x_q          <= '0;
         z_prev       <= '0;
         v0           <= 1'b0;
         v1           <= 1'b0;
         v2           <= 1'b0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
      end else begin
         cnt          <= cnt + DIV_LOG2'(1);
         acc          <= wrap ? '0 : acc_total;
         v0           <= wrap;
         v1           <= v0;
         v2           <= v1;
         sample_valid <= v2;
         if (wrap) begin
            avg <= acc_total[ACC_W-1:DIV_LOG2];
         end
         if (v0) begin
            x_q <= {avg - DAC_MIDPOINT, 8'h00};
         end
         // Filter state keeps running under mute so unmuting is step-free
         if (v2) begin
            z_prev     <= z_cur;
            sample_out <= mute ? '0 : 16'(z_cur >>> (2'd3 - volume));
         end
      end
   end

   ma216_dc_block #(
      .HP_SHIFT (HP_SHIFT)
   ) u_dc (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (v1),
      .x       (x_q),
      .y       (y)
   );

endmodule

// File: doc/ma216_audio_out.md
MA216_AUDIO_OUT -- requirements
Module: ma216_audio_out

Interface
REQ-001 SHALL have parameter DIV_LOG2, default 5, meaning decimation window of 2^DIV_LOG2 clk cycles per output sample.
REQ-002 SHALL have parameter HP_SHIFT, default 8, meaning DC-blocker leak coefficient 2^-HP_SHIFT.
REQ-003 SHALL have parameter LP_SHIFT, default 2, meaning low-pass coefficient 2^-LP_SHIFT; value 0 = low-pass bypass.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port dac_in, input, 8, unsigned sound-board DAC latch value, 0x80 = silence.
REQ-007 SHALL have port volume, input, 2, attenuation select: 3 = 0 dB, 2 = -6 dB, 1 = -12 dB, 0 = -18 dB.
REQ-008 SHALL have port mute, input, 1, forces output samples to zero.
REQ-009 SHALL have port sample_out, output, 16, signed two's-complement audio sample.
REQ-010 SHALL have port sample_valid, output, 1, one-cycle strobe marking a new sample_out.

Function
REQ-011 SHALL run a DIV_LOG2-bit window counter incrementing every clk, wrapping from 2^DIV_LOG2-1 to 0.
REQ-012 SHALL add dac_in to an (8+DIV_LOG2)-bit accumulator every clk, including the wrap cycle; accumulator never overflows.
REQ-013 SHALL on wrap cycle (stage 0) register avg = acc_total >> DIV_LOG2 and restart accumulator with 0 (next window begins next clk).
REQ-014 SHALL stage 1 form x = (avg - 128) << 8 as signed 16-bit (range -32768..+32512).
REQ-015 SHALL stage 2 compute DC-blocker y = x - x_prev + y_prev - (y_prev >>> HP_SHIFT) in >=18-bit signed, saturate to [-32768, 32767], then update x_prev = x, y_prev = saturated y.
REQ-016 SHALL stage 3 compute z = z_prev + ((y - z_prev) >>> LP_SHIFT), update z_prev = z; LP_SHIFT = 0 gives z = y.
REQ-017 SHALL stage 3 output sample_out = mute ? 0 : z >>> (3 - volume), with volume and mute sampled in that cycle.
REQ-018 SHALL assert sample_valid for exactly one clk, aligned with sample_out update, 3 clk after the window wrap cycle; sample_out holds between strobes.
REQ-019 SHALL keep filter state (x_prev, y_prev, z_prev) updating while mute is high so unmuting causes no step.
REQ-020 SHALL sample dac_in every clk regardless of pipeline activity; a dac_in change within a window contributes proportionally to the average.
REQ-021 SHALL never emit sample_valid in consecutive cycles (requires DIV_LOG2 >= 2; smaller values are illegal).

Reset
REQ-022 SHALL, while reset_n is low at a clk edge, clear counter, accumulator, all pipeline registers, x_prev, y_prev, z_prev, sample_out = 0, sample_valid = 0.
REQ-023 SHALL discard a partially accumulated window and in-flight pipeline data on reset; first valid sample appears 2^DIV_LOG2 + 3 clk after reset_n rises.

Structure
REQ-024 SHALL place constants DAC_MIDPOINT (0x80), SAMPLE_MAX (32767), SAMPLE_MIN (-32768) and the saturate-to-16-bit function in shared package ma216_audio_pkg.
REQ-025 SHALL instantiate one sub-module ma216_dc_block implementing REQ-015 (inputs: clk, reset_n, enable, x; output: y).
REQ-026 SHALL connect dac_in directly to the sound board's 8-bit DAC latch output.

Verification
REQ-027 SHALL test reset: reset_n low 4 clk with dac_in = 0xFF -> sample_out = 0, sample_valid = 0; first strobe exactly 35 clk after release (defaults).
REQ-028 SHALL test silence: dac_in = 0x80 for 100 windows -> every sample_out = 0, strobes exactly 32 clk apart.
REQ-029 SHALL test step (LP_SHIFT = 0, volume = 3): settle at 0x80, step to 0xFF on a window boundary -> first new sample 32512, second 32385 (32512 - 127), decaying toward 0.
REQ-030 SHALL test saturation: hold 0x00 for 4096 windows, then 0xFF -> first post-step y and sample_out = 32767 (LP_SHIFT = 0).
REQ-031 SHALL test volume/mute: step case with volume = 1 -> first sample 8128; mute asserted -> 0 on next strobe, deassert -> output resumes following unmuted filter state without a reset transient.
REQ-032 SHALL test mid-window reset: reset_n low for 1 clk at counter = 17 -> no strobe for 35 clk after release, accumulator restart verified by 0x80 input giving 0.
